// File: rtl/flopoco_to_ieee_stream.sv
// flopoco_to_ieee_stream
//   Converts 34-bit FloPoCo results {exn[1:0], sign, exp[7:0], frac[22:0]} into
//   canonical IEEE-754 single-precision words through a 2-stage valid/ready
//   pipeline. Also holds the last transferred word and saturating counters of
//   NaN, overflow and flush-to-zero results.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake, in_data = FloPoCo value
//   out_valid/out_ready    output handshake, out_data = IEEE word
//   out_flags              {nan, inf, ovf, ufl} for out_data
//   last_result            last word transferred out
//   nan/ovf/ufl_count      saturating counts of transferred flagged results
module flopoco_to_ieee_stream #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [33:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_flags,
  output logic [31:0]      last_result,
  output logic [CNT_W-1:0] nan_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] ufl_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        s1_v;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [22:0] s1_frac;
  logic        s1_norm;
  logic        s1_inf;
  logic        s1_nan;
  logic        s1_e_min;
  logic        s1_e_max;

  logic        s2_v;
  logic        s2_adv;
  logic        s1_adv;
  logic        out_xfer;

  logic [31:0] conv_word;
  logic [3:0]  conv_flags;

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;
  assign out_xfer  = s2_v && out_ready;

  // Stage 1: decode the FloPoCo fields into one-hot class bits.
  // Zero class needs no bit: it falls through to the all-zero default below.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_norm  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_e_min <= 1'b0;
      s1_e_max <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_data[31];
        s1_exp   <= in_data[30:23];
        s1_frac  <= in_data[22:0];
        s1_norm  <= (in_data[33:32] == 2'b01);
        s1_inf   <= (in_data[33:32] == 2'b10);
        s1_nan   <= (in_data[33:32] == 2'b11);
        s1_e_min <= (in_data[30:23] == 8'h00);
        s1_e_max <= (in_data[30:23] == 8'hFF);
      end
    end
  end

  // IEEE word and flags {nan, inf, ovf, ufl}. Zero results drop the sign.
  always_comb begin
    conv_word  = 32'h0000_0000;
    conv_flags = 4'b0000;
    if (s1_nan) begin
      conv_word  = CANON_NAN;
      conv_flags = 4'b1000;
    end else if (s1_inf) begin
      conv_word  = {s1_sign, 8'hFF, 23'h0};
      conv_flags = 4'b0100;
    end else if (s1_norm) begin
      if (s1_e_min) begin
        conv_flags = 4'b0001;
      end else if (s1_e_max) begin
        conv_word  = {s1_sign, 8'hFF, 23'h0};
        conv_flags = 4'b0110;
      end else begin
        conv_word = {s1_sign, s1_exp, s1_frac};
      end
    end
  end

  // Stage 2: output register, held stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v      <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data  <= conv_word;
        out_flags <= conv_flags;
      end
    end
  end

  // Hold register and saturating counters, updated only on output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_result <= '0;
      nan_count   <= '0;
      ovf_count   <= '0;
      ufl_count   <= '0;
    end else if (out_xfer) begin
      last_result <= out_data;
      if (out_flags[3] && nan_count != CNT_MAX) nan_count <= nan_count + CNT_W'(1);
      if (out_flags[1] && ovf_count != CNT_MAX) ovf_count <= ovf_count + CNT_W'(1);
      if (out_flags[0] && ufl_count != CNT_MAX) ufl_count <= ufl_count + CNT_W'(1);
    end
  end

endmodule
